// File: rtl/i2c_target_pkg.sv
// Shared types and defaults for the I2C target: FSM state encoding and
// the default address / filter depth.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_e;

  localparam logic [6:0] C_ADDR_DEFAULT   = 7'h50;
  localparam int         C_FILTER_DEFAULT = 4;

endpackage

// File: rtl/i2c_target_line_filter.sv
// One bus line: 2-flop synchronizer, stability filter (C_FILTER equal samples
// needed to flip the filtered level) and registered rise/fall strobes.
module i2c_line_filter #(
  parameter int C_FILTER = 4
) (
  input  logic I_clk_100Mhz,
  input  logic I_rst_n,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    cnt_d  = 4'd0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == 4'(C_FILTER - 1)) begin
        filt_d = sync_q[1];
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Idle bus level is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge I_clk_100Mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= 4'd0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign line_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: filtered SCL/SDA front end, START/STOP detection, 7-bit address
// match, write-byte delivery and read-byte fetch. SDA is driven open-drain only.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] C_ADDR   = C_ADDR_DEFAULT,
  parameter int         C_FILTER = C_FILTER_DEFAULT
) (
  input  logic       I_clk_100Mhz,
  input  logic       I_rst_n,
  input  logic       I_SCL,
  input  logic       I_SDA,
  output logic       O_SDA_OE,
  output logic       O_START,
  output logic       O_STOP,
  output logic       O_BUSY,
  output logic [7:0] O_RX_DATA,
  output logic       O_RX_VALID,
  output logic       O_RD_REQ,
  input  logic [7:0] I_TX_DATA,
  output logic       O_RD_NACK
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.C_FILTER(C_FILTER)) u_scl_filt (
    .I_clk_100Mhz (I_clk_100Mhz),
    .I_rst_n      (I_rst_n),
    .line_i       (I_SCL),
    .line_o       (scl_f),
    .rise_o       (scl_rise),
    .fall_o       (scl_fall)
  );

  i2c_line_filter #(.C_FILTER(C_FILTER)) u_sda_filt (
    .I_clk_100Mhz (I_clk_100Mhz),
    .I_rst_n      (I_rst_n),
    .line_i       (I_SDA),
    .line_o       (sda_f),
    .rise_o       (sda_rise),
    .fall_o       (sda_fall)
  );

  state_e     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] shift_nx;
  logic [7:0] rx_data_q, rx_data_d;
  logic [6:0] tx_q, tx_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       rxv_q, rxv_d;
  logic       rdreq_q, rdreq_d;
  logic       nack_q, nack_d;
  logic       start_det, stop_det;

  assign start_det = scl_f & sda_fall;
  assign stop_det  = scl_f & sda_rise;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    tx_d      = tx_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    rxv_d     = 1'b0;
    rdreq_d   = 1'b0;
    nack_d    = 1'b0;
    shift_nx  = {shift_q, sda_f};

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else if (start_det) begin
      state_d  = S_ADDR;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      bitcnt_d = 4'd0;
      start_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shift_d  = shift_nx[6:0];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (shift_nx[7:1] == C_ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_nx[0];
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        // oe_q doubles as the "ACK bit already driven" flag in both ACK states.
        S_ADDR_ACK: begin
          if (scl_rise && rw_q) rdreq_d = 1'b1;
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else if (rw_q) begin
              state_d  = S_RD_DATA;
              tx_d     = I_TX_DATA[6:0];
              oe_d     = ~I_TX_DATA[7];
              bitcnt_d = 4'd1;
            end else begin
              state_d  = S_WR_DATA;
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shift_d  = shift_nx[6:0];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              rx_data_d = shift_nx;
              rxv_d     = 1'b1;
              state_d   = S_WR_ACK;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = S_WR_DATA;
            end
          end
        end
        // bitcnt counts bits already placed on SDA; 0 means load a fresh byte.
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              tx_d     = I_TX_DATA[6:0];
              oe_d     = ~I_TX_DATA[7];
              bitcnt_d = 4'd1;
            end else if (bitcnt_q == 4'd8) begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = S_RD_ACK;
            end else begin
              oe_d     = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              rdreq_d  = 1'b1;
              bitcnt_d = 4'd0;
              state_d  = S_RD_DATA;
            end else begin
              nack_d  = 1'b1;
              state_d = S_IGNORE;
            end
          end
        end
        S_IGNORE: oe_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk_100Mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= 4'd0;
      shift_q   <= 7'd0;
      rx_data_q <= 8'h00;
      tx_q      <= 7'd0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      rxv_q     <= 1'b0;
      rdreq_q   <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      tx_q      <= tx_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      rxv_q     <= rxv_d;
      rdreq_q   <= rdreq_d;
      nack_q    <= nack_d;
    end
  end

  assign O_SDA_OE   = oe_q;
  assign O_START    = start_q;
  assign O_STOP     = stop_q;
  assign O_BUSY     = busy_q;
  assign O_RX_DATA  = rx_data_q;
  assign O_RX_VALID = rxv_q;
  assign O_RD_REQ   = rdreq_q;
  assign O_RD_NACK  = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged ~400 kHz controller on a
// wired-AND SDA, pulse counters and a received-byte log.
module tb_i2c_target;

  localparam int Q = 620;  // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       ctl_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       oe, start_p, stop_p, busy, rxv, rdreq, nack;
  logic [7:0] rx_data;

  assign sda_bus = ctl_sda & ~oe;

  i2c_target #(.C_ADDR(7'h50), .C_FILTER(4)) dut (
    .I_clk_100Mhz (clk),
    .I_rst_n      (rst_n),
    .I_SCL        (scl),
    .I_SDA        (sda_bus),
    .O_SDA_OE     (oe),
    .O_START      (start_p),
    .O_STOP       (stop_p),
    .O_BUSY       (busy),
    .O_RX_DATA    (rx_data),
    .O_RX_VALID   (rxv),
    .O_RD_REQ     (rdreq),
    .I_TX_DATA    (tx_data),
    .O_RD_NACK    (nack)
  );

  always #5 clk = ~clk;

  int n_start, n_stop, n_rxv, n_rdreq, n_nack, n_oe, n_busy;
  logic [7:0] rx_log [16];

  always @(posedge clk) begin
    if (start_p) n_start <= n_start + 1;
    if (stop_p)  n_stop  <= n_stop + 1;
    if (rdreq)   n_rdreq <= n_rdreq + 1;
    if (nack)    n_nack  <= n_nack + 1;
    if (oe)      n_oe    <= n_oe + 1;
    if (busy)    n_busy  <= n_busy + 1;
    if (rxv) begin
      rx_log[n_rxv % 16] <= rx_data;
      n_rxv <= n_rxv + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ctl_sda = b;
    if (glitch) begin
      #200; scl = 1'b1; #30; scl = 1'b0; #390;
    end else begin
      #Q;
    end
    scl = 1'b1; #Q; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    ctl_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    b = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    ctl_sda = 1'b1; scl = 1'b1; #Q;
    ctl_sda = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    ctl_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    ctl_sda = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    ctl_sda = 1'b0; #Q;
    scl = 1'b1; #Q;
    ctl_sda = 1'b1; #Q; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack_bit, input logic [7:0] next_tx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    tx_data = next_tx;
    send_bit(nack_bit, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int s_start, s_stop, s_rxv, s_rdreq, s_nack, s_oe, s_busy;

    #50;
    check("rst_oe", oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {start_p, stop_p, rxv, rdreq, nack}, 0);
    #50 rst_n = 1'b1;
    #200;

    // Write 0x3C, 0xC5 to address 0x50
    s_start = n_start; s_stop = n_stop; s_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA0, -1, ack); check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    write_byte(8'h3C, -1, ack); check("wr_d0_ack", ack, 0);
    write_byte(8'hC5, -1, ack); check("wr_d1_ack", ack, 0);
    i2c_stop();
    check("wr_rxv_cnt", n_rxv - s_rxv, 2);
    check("wr_byte0", rx_log[s_rxv % 16], 8'h3C);
    check("wr_byte1", rx_log[(s_rxv + 1) % 16], 8'hC5);
    check("wr_rx_hold", rx_data, 8'hC5);
    check("wr_start_cnt", n_start - s_start, 1);
    check("wr_stop_cnt", n_stop - s_stop, 1);
    check("wr_busy_end", busy, 0);

    // Wrong address 0x51
    s_oe = n_oe; s_busy = n_busy; s_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA2, -1, ack); check("bad_addr_nack", ack, 1);
    write_byte(8'h55, -1, ack); check("bad_data_nack", ack, 1);
    i2c_stop();
    check("bad_oe_cnt", n_oe - s_oe, 0);
    check("bad_busy_cnt", n_busy - s_busy, 0);
    check("bad_rxv_cnt", n_rxv - s_rxv, 0);

    // Read 0x96 (ACK) then 0x5A (NACK)
    s_rdreq = n_rdreq; s_nack = n_nack;
    tx_data = 8'h96;
    i2c_start();
    write_byte(8'hA1, -1, ack); check("rd_addr_ack", ack, 0);
    read_byte(rd, 1'b0, 8'h5A); check("rd_byte0", rd, 8'h96);
    read_byte(rd, 1'b1, 8'h00); check("rd_byte1", rd, 8'h5A);
    check("rd_oe_after_nack", oe, 0);
    i2c_stop();
    check("rd_req_cnt", n_rdreq - s_rdreq, 2);
    check("rd_nack_cnt", n_nack - s_nack, 1);

    // Write one byte, repeated START, then read
    s_start = n_start; s_rxv = n_rxv;
    tx_data = 8'h77;
    i2c_start();
    write_byte(8'hA0, -1, ack); check("rs_waddr_ack", ack, 0);
    write_byte(8'h11, -1, ack); check("rs_wdata_ack", ack, 0);
    i2c_rstart();
    write_byte(8'hA1, -1, ack); check("rs_raddr_ack", ack, 0);
    read_byte(rd, 1'b1, 8'h00); check("rs_rd_byte", rd, 8'h77);
    i2c_stop();
    check("rs_start_cnt", n_start - s_start, 2);
    check("rs_rxv_cnt", n_rxv - s_rxv, 1);
    check("rs_wr_byte", rx_log[s_rxv % 16], 8'h11);

    // 3-cycle SCL glitch during a write byte
    s_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h6B, 3, ack); check("gl_ack", ack, 0);
    i2c_stop();
    check("gl_rxv_cnt", n_rxv - s_rxv, 1);
    check("gl_byte", rx_log[s_rxv % 16], 8'h6B);

    // Reset mid read byte while OE is driving a 0 bit
    s_rdreq = n_rdreq;
    tx_data = 8'h00;
    i2c_start();
    write_byte(8'hA1, -1, ack);
    check("mr_oe_pre", oe, 1);
    recv_bit(ack);
    recv_bit(ack);
    rst_n = 1'b0;
    #1 check("mr_oe_async", oe, 0);
    check("mr_rx_data", rx_data, 8'h00);
    #19 rst_n = 1'b1;
    s_oe = n_oe; s_busy = n_busy; s_rxv = n_rxv; s_rdreq = n_rdreq; s_nack = n_nack;
    for (int i = 0; i < 6; i++) recv_bit(ack);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    i2c_stop();
    check("mr_oe_cnt", n_oe - s_oe, 0);
    check("mr_busy_cnt", n_busy - s_busy, 0);
    check("mr_activity", (n_rxv - s_rxv) + (n_rdreq - s_rdreq) + (n_nack - s_nack), 0);

    // Recovery after next START
    s_rxv = n_rxv;
    i2c_start();
    write_byte(8'hA0, -1, ack); check("rc_addr_ack", ack, 0);
    write_byte(8'h42, -1, ack);
    i2c_stop();
    check("rc_byte", rx_log[s_rxv % 16], 8'h42);

    #100;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) receiver/transmitter: the bus-side counterpart to the team's SCL-generating I2C controller. Samples raw SCL/SDA with the 100 MHz system clock, detects START/STOP, matches a 7-bit address, ACKs, and delivers write bytes to or fetches read bytes from user logic. It drives SDA open-drain through an output-enable only and never drives SCL (no clock stretching).

## Interface
Parameters:
- C_ADDR, 7'h50, target address matched against the first byte after START.
- C_FILTER, 4, consecutive identical synchronized samples (1..15) required to change a filtered line.

Ports:
- I_clk_100Mhz  in  1  system clock, 100 MHz.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_SCL  in  1  raw bus SCL.
- I_SDA  in  1  raw bus SDA.
- O_SDA_OE  out  1  1 = pull SDA low; 0 = release.
- O_START  out  1  one-cycle pulse on START or repeated START.
- O_STOP  out  1  one-cycle pulse on STOP.
- O_BUSY  out  1  high while addressed (address matched) until STOP/START.
- O_RX_DATA  out  8  last written byte, held until next write byte.
- O_RX_VALID  out  1  one-cycle pulse when O_RX_DATA updates.
- O_RD_REQ  out  1  one-cycle pulse requesting the next read byte.
- I_TX_DATA  in  8  read byte; sampled as defined under Timing.
- O_RD_NACK  out  1  one-cycle pulse when controller NACKs a read byte.

## Operation
- Front end: 2-flop synchronizer per line, then stability filter per line; filtered SCL/SDA (reset value 1) change only after C_FILTER equal consecutive samples. Edge detect on filtered lines yields scl_rise/scl_fall.
- START: filtered SDA falls while filtered SCL high. STOP: filtered SDA rises while SCL high. Both act in every state.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: wait for START -> ADDR.
- ADDR: shift SDA MSB-first on 8 scl_rise; addr[7:1]==C_ADDR -> ADDR_ACK, O_BUSY=1; else -> IGNORE.
- ADDR_ACK: OE=1 from next scl_fall to following scl_fall. R/W=0 -> WR_DATA; R/W=1 -> RD_DATA.
- WR_DATA: 8 scl_rise shift; on 8th, O_RX_DATA updated, O_RX_VALID pulsed -> WR_ACK (always ACK) -> WR_DATA.
- RD_DATA: on each scl_fall, OE = ~bit (MSB first); after 8th bit's scl_fall window ends, OE released -> RD_ACK.
- RD_ACK: sample SDA on scl_rise: 0 -> O_RD_REQ, RD_DATA; 1 -> O_RD_NACK, IGNORE.
- IGNORE: OE=0; wait for START/STOP.
- STOP in any state -> IDLE, OE=0, O_BUSY=0. START in any state -> ADDR, OE=0, O_BUSY=0, bit counter cleared.
- Bit counter 4 bits, 0..8, cleared on START and on ACK phase completion.

## Timing
- Raw-to-filtered latency: 2 + C_FILTER cycles; all pulse outputs are asserted the cycle after the filtered event is detected.
- OE changes only the cycle after a filtered scl_fall (or immediately on START/STOP/reset release).
- O_RD_REQ pulses one cycle after the scl_rise of the 9th clock of the address byte (R/W=1, matched) or of an ACKed read byte. I_TX_DATA is latched on the next scl_fall; user logic has at least half an SCL period (>=50 cycles at 1 MHz SCL) to present it.
- O_RX_VALID pulses one cycle after the 8th scl_rise of a write byte.
- Reset: all outputs 0, O_RX_DATA=8'h00, state IDLE, filtered lines 1.
- Reset mid-transfer: OE released immediately (asynchronous); block ignores bus until next START.
- Glitches shorter than C_FILTER cycles on either line: no effect.

## Structure
- Shared package: state enumeration, C_ADDR default, C_FILTER default.
- One sub-module i2c_line_filter (synchronizer + stability filter + rise/fall detect), instantiated for SCL and SDA.

## Test plan
- Write 0xA0 (addr 0x50 W), data 0x3C, 0xC5, STOP at 400 kHz -> ACK on 3 ninth clocks; O_RX_VALID twice with 0x3C, 0xC5; O_START, O_STOP once each.
- Address 0x51 write -> no ACK (OE never 1), O_BUSY stays 0, following data ignored.
- Read 0xA1, I_TX_DATA=0x96 then 0x5A, controller ACK then NACK -> SDA carries 0x96, 0x5A; O_RD_REQ pulses 2, O_RD_NACK 1, OE released after NACK.
- Repeated START after one write byte, then read 0xA1 -> O_START twice, state restarts at ADDR, read proceeds.
- 3-cycle glitch on SCL with C_FILTER=4 during WR_DATA -> no extra bit shifted; received byte correct.
- Assert I_rst_n low mid read byte while OE=1 -> OE=0 same cycle; no activity until next START.
